ssd_display_driver: RTL and testbench

- Downstream consumer of the datapath's 13-bit `ssd` debug output.
- Converts the binary value to 4 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the datapath top and the board pins.

---
 rtl/ssd_pkg.sv | 29 ++
 rtl/bcd_to_7seg.sv | 30 +++
 rtl/ssd_display_driver.sv | 149 ++++++++++++++
 tb/tb_ssd_display_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display driver.
package ssd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SEG_W      = 7;

    // Conversion engine states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module bcd_to_7seg
    import ssd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    // Decode one digit; non-decimal codes and blanked digits turn all segments off.
    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ssd_display_driver.sv
// Binary-to-BCD (double-dabble) converter driving a multiplexed 4-digit
// common-anode seven-segment display.
module ssd_display_driver
    import ssd_pkg::*;
#(
    parameter int unsigned DATA_W       = 13,
    parameter int unsigned REFRESH_BITS = 20,
    parameter int unsigned BLANK_LZ     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    output logic [3:0]        anode,
    output logic [6:0]        cathode,
    output logic              dp,
    output logic              busy,
    output logic              conv_done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t                  state;
    state_t                  state_next;
    logic [DATA_W-1:0]       shift_reg;
    logic [DATA_W-1:0]       last_value;
    logic [BCD_W-1:0]        acc;
    logic [BCD_W-1:0]        acc_adj;
    logic [BCD_W-1:0]        display;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    force_conv;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic                    start;
    logic                    shift_last;
    logic                    busy_next;
    logic                    conv_done_next;
    logic [1:0]              idx;
    logic [DIGIT_W-1:0]      cur_digit;
    logic [3:1]              lz;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [SEG_W-1:0]        seg_c;

    assign start      = (value != last_value) || force_conv;
    assign shift_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign idx        = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign cur_digit  = display[{idx, 2'b00} +: DIGIT_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: one shift per data bit, then a single commit cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start)      state_next = ST_SHIFT;
            ST_SHIFT:  if (shift_last) state_next = ST_COMMIT;
            ST_COMMIT:                 state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        busy_next      = 1'b0;
        conv_done_next = 1'b0;
        case (state)
            ST_IDLE:   busy_next      = start;
            ST_SHIFT:  busy_next      = 1'b1;
            ST_COMMIT: conv_done_next = 1'b1;
            default:   busy_next      = 1'b0;
        endcase
    end

    // Add-3 correction on every BCD nibble that would overflow when doubled.
    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (acc[k*DIGIT_W +: DIGIT_W] >= 4'd5)
                acc_adj[k*DIGIT_W +: DIGIT_W] = acc[k*DIGIT_W +: DIGIT_W] + 4'd3;
        end
    end

    // Conversion datapath and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            last_value <= '0;
            acc        <= '0;
            display    <= '0;
            bit_cnt    <= '0;
            force_conv <= 1'b1;
            busy       <= 1'b0;
            conv_done  <= 1'b0;
        end else begin
            busy      <= busy_next;
            conv_done <= conv_done_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg  <= value;
                        last_value <= value;
                        acc        <= '0;
                        force_conv <= 1'b0;
                        bit_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    acc       <= {acc_adj[BCD_W-2:0], shift_reg[DATA_W-1]};
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                ST_COMMIT: display <= acc;
                default: ;
            endcase
        end
    end

    // Leading-zero blanking; the ones digit is always shown.
    always_comb begin
        lz[3]     = (display[15:12] == 4'd0);
        lz[2]     = lz[3] && (display[11:8] == 4'd0);
        lz[1]     = lz[2] && (display[7:4] == 4'd0);
        blank_vec = (BLANK_LZ != 0) ? {lz[3:1], 1'b0} : '0;
    end

    bcd_to_7seg u_seg (
        .digit (cur_digit),
        .blank (blank_vec[idx]),
        .seg_c (seg_c)
    );

    // Free-running refresh counter and registered digit multiplexer.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            anode       <= 4'b1111;
            cathode     <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            anode       <= ~(4'b0001 << idx);
            cathode     <= seg_c;
            dp          <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Self-checking bench: per-cycle reference model plus table and corner sequences.
module tb_ssd_display_driver;

    localparam int unsigned DW = 13;
    localparam int unsigned RB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] value = '0;

    logic [3:0] anode_b, anode_n;
    logic [6:0] cathode_b, cathode_n;
    logic       dp_b, dp_n, busy_b, busy_n, done_b, done_n;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ssd_display_driver #(.DATA_W(DW), .REFRESH_BITS(RB), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .value(value), .anode(anode_b), .cathode(cathode_b),
        .dp(dp_b), .busy(busy_b), .conv_done(done_b)
    );

    ssd_display_driver #(.DATA_W(DW), .REFRESH_BITS(RB), .BLANK_LZ(0)) dut_n (
        .clk(clk), .rst(rst), .value(value), .anode(anode_n), .cathode(cathode_n),
        .dp(dp_n), .busy(busy_n), .conv_done(done_n)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected segments of digit k of a decimal value.
    function automatic logic [6:0] exp_seg(input int disp, input int k, input bit blank_lz);
        int pw = 1;
        for (int i = 0; i < k; i++) pw *= 10;
        if (blank_lz && k > 0 && disp < pw) return 7'b1111111;
        return seg_tab[(disp / pw) % 10];
    endfunction

    // Reference model: a conversion is a 15-cycle job started whenever the
    // engine is free and value differs from the last accepted one.
    int         m_cnt = 0, m_disp = 0, m_last = 0, m_conv = 0, m_timer = 0, m_k = 0;
    bit         m_force = 1, m_valid = 0;
    logic [3:0] e_anode;
    logic [6:0] e_cat_b, e_cat_n;
    logic       e_busy, e_done;

    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            m_cnt = 0; m_disp = 0; m_last = 0; m_force = 1; m_timer = 0;
            e_anode = 4'b1111; e_cat_b = 7'b1111111; e_cat_n = 7'b1111111;
            e_busy = 0; e_done = 0;
        end else begin
            m_k     = (m_cnt / (1 << (RB - 2))) % 4;
            e_anode = 4'b1111 ^ (4'b0001 << m_k);
            e_cat_b = exp_seg(m_disp, m_k, 1);
            e_cat_n = exp_seg(m_disp, m_k, 0);
            m_cnt   = (m_cnt + 1) % (1 << RB);
            e_done  = 0;
            if (m_timer == 0) begin
                if (int'(value) != m_last || m_force) begin
                    m_conv = int'(value); m_last = int'(value); m_force = 0;
                    m_timer = DW + 1; e_busy = 1;
                end else e_busy = 0;
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_disp = m_conv; e_done = 1; e_busy = 0;
                end else e_busy = 1;
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            logic bad_nib;
            chk("cycle_blank", 32'({anode_b, cathode_b, dp_b, busy_b, done_b}),
                32'({e_anode, e_cat_b, 1'b1, e_busy, e_done}));
            chk("cycle_noblank", 32'({anode_n, cathode_n, dp_n, busy_n, done_n}),
                32'({e_anode, e_cat_n, 1'b1, e_busy, e_done}));
            bad_nib = 1'b0;
            for (int k = 0; k < 4; k++)
                if (dut_b.acc[k*4 +: 4] > 4'd9) bad_nib = 1'b1;
            chk("acc_bcd_digit", 32'(bad_nib), 32'd0);
        end
    end

    // Wait for conv_done, counting busy cycles before it.
    task automatic wait_conv(output int busy_cycles);
        bit seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done_b) seen = 1;
            else if (busy_b) busy_cycles++;
        end
        if (!seen) chk("conv_timeout", 32'd1, 32'd0);
    endtask

    // Capture the cathode pattern of every digit over one refresh period.
    task automatic sample_period(output logic [3:0][6:0] ob, output logic [3:0][6:0] on);
        logic [3:0] sel;
        ob = '1; on = '1;
        repeat (1 << RB) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                sel = 4'b0001 << k;
                if (anode_b == ~sel) ob[k] = cathode_b;
                if (anode_n == ~sel) on[k] = cathode_n;
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0]    val;
        logic [3:0][6:0]  seg_bl;
        logic [3:0][6:0]  seg_nb;
    } vec_t;

    vec_t            tbl [7];
    logic [3:0][6:0] ob, on;
    int              bc, pulses;

    initial begin
        tbl[0] = '{13'd1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
        tbl[1] = '{13'd8191, {7'h00, 7'h79, 7'h10, 7'h79}, {7'h00, 7'h79, 7'h10, 7'h79}};
        tbl[2] = '{13'd7,    {7'h7f, 7'h7f, 7'h7f, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h78}};
        tbl[3] = '{13'd0,    {7'h7f, 7'h7f, 7'h7f, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
        tbl[4] = '{13'd1005, {7'h79, 7'h40, 7'h40, 7'h12}, {7'h79, 7'h40, 7'h40, 7'h12}};
        tbl[5] = '{13'd60,   {7'h7f, 7'h7f, 7'h02, 7'h40}, {7'h40, 7'h40, 7'h02, 7'h40}};
        tbl[6] = '{13'd4000, {7'h19, 7'h40, 7'h40, 7'h40}, {7'h19, 7'h40, 7'h40, 7'h40}};

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 32'({anode_b, cathode_b, dp_b, busy_b, done_b}),
                32'({4'b1111, 7'h7f, 1'b1, 1'b0, 1'b0}));
        end
        rst = 1'b0;
        wait_conv(bc);
        chk("post_reset_busy_len", 32'(bc), 32'd14);
        sample_period(ob, on);
        chk("post_reset_blank", 32'(ob), 32'({7'h7f, 7'h7f, 7'h7f, 7'h40}));
        chk("post_reset_noblank", 32'(on), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

        // Table-driven values.
        for (int i = 0; i < 7; i++) begin
            value = tbl[i].val;
            wait_conv(bc);
            chk("tbl_busy_len", 32'(bc), 32'd14);
            sample_period(ob, on);
            chk("tbl_digits_blank", 32'(ob), 32'(tbl[i].seg_bl));
            chk("tbl_digits_noblank", 32'(on), 32'(tbl[i].seg_nb));
        end

        // Value changed five cycles into a conversion.
        value = 13'd1234;
        repeat (6) @(negedge clk);
        value = 13'd5678;
        pulses = 0;
        repeat (45) begin
            @(negedge clk);
            if (done_b) pulses++;
        end
        chk("requeue_pulses", 32'(pulses), 32'd2);
        sample_period(ob, on);
        chk("requeue_final", 32'(ob), 32'({7'h12, 7'h02, 7'h78, 7'h00}));

        // One-cycle reset in the middle of a conversion.
        value = 13'd4321;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midconv_reset", 32'({anode_b, cathode_b, dp_b, busy_b, done_b}),
            32'({4'b1111, 7'h7f, 1'b1, 1'b0, 1'b0}));
        rst = 1'b0;
        wait_conv(bc);
        chk("midconv_busy_len", 32'(bc), 32'd14);
        sample_period(ob, on);
        chk("midconv_digits", 32'(ob), 32'({7'h19, 7'h30, 7'h24, 7'h79}));

        // Randomized values, hold times and occasional resets.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) value = DW'($urandom_range(0, 99));
            else                          value = DW'($urandom_range(0, 8191));
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
